// File: rtl/m3_run_sequencer.sv
// Run-state controller for the three-phase drive: turns panel controls into a registered
// bridge enable, direction, slewed frequency and power command for the phase generator.
module m3_run_sequencer #(
  parameter int unsigned FREQ_W    = 16,
  parameter int unsigned PWR_W     = 8,
  parameter int unsigned FREQ_MIN  = 100,
  parameter int unsigned FREQ_MAX  = 4000,
  parameter int unsigned FREQ_STEP = 50,
  parameter int unsigned RAMP_INC  = 1,
  parameter int unsigned RAMP_TICK = 50000,
  parameter int unsigned PWR_MIN   = 32,
  parameter int unsigned PWR_MAX   = 255,
  parameter int unsigned PWR_STEP  = 16,
  parameter int unsigned STOP_HOLD = 500000
) (
  input  logic              clk50mhzI,
  input  logic              nRstI,
  input  logic              m3startI,
  input  logic              m3forceStopI,
  input  logic              m3invRotateI,
  input  logic              m3freqINCi,
  input  logic              m3freqDECi,
  input  logic              m3powerINCi,
  input  logic              m3powerDECi,
  output logic              m3enO,
  output logic              m3dirO,
  output logic [FREQ_W-1:0] m3freqO,
  output logic [PWR_W-1:0]  m3powerO,
  output logic [2:0]        m3stateO
);

  localparam int unsigned TickW = $clog2(RAMP_TICK + 1);
  localparam int unsigned HoldW = $clog2(STOP_HOLD + 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRampUp = 3'd1;
  localparam logic [2:0] StRun    = 3'd2;
  localparam logic [2:0] StRampDn = 3'd3;
  localparam logic [2:0] StHold   = 3'd4;
  localparam logic [2:0] StFstop  = 3'd5;

  localparam logic [FREQ_W-1:0] FMin  = FREQ_W'(FREQ_MIN);
  localparam logic [FREQ_W:0]   FMaxX = (FREQ_W+1)'(FREQ_MAX);
  localparam logic [FREQ_W:0]   FMinX = (FREQ_W+1)'(FREQ_MIN);
  localparam logic [FREQ_W:0]   FStep = (FREQ_W+1)'(FREQ_STEP);
  localparam logic [FREQ_W:0]   FInc  = (FREQ_W+1)'(RAMP_INC);
  localparam logic [PWR_W:0]    PMaxX = (PWR_W+1)'(PWR_MAX);
  localparam logic [PWR_W:0]    PMinX = (PWR_W+1)'(PWR_MIN);
  localparam logic [PWR_W:0]    PStep = (PWR_W+1)'(PWR_STEP);

  logic [2:0]        state_q, state_d;
  logic              en_q, en_d, dir_q, dir_d;
  logic [FREQ_W-1:0] freq_q, freq_d, target_q, target_d;
  logic [PWR_W-1:0]  pwr_q, pwr_d, pwr_out_q, pwr_out_d;
  logic [3:0]        prev_q;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;

  logic              finc, fdec, pinc, pdec, tick, tick_clr, stop_req, ramping;
  logic [FREQ_W:0]   t_up, t_dn, f_up, f_dn;
  logic [PWR_W:0]    p_up, p_dn;
  logic [FREQ_W-1:0] slew;

  assign finc = m3freqINCi  & ~prev_q[3];
  assign fdec = m3freqDECi  & ~prev_q[2];
  assign pinc = m3powerINCi & ~prev_q[1];
  assign pdec = m3powerDECi & ~prev_q[0];

  assign tick     = (tick_cnt_q == TickW'(RAMP_TICK - 1));
  assign stop_req = ~m3startI | (m3invRotateI != dir_q);
  assign ramping  = (state_q == StRampUp) | (state_q == StRun) | (state_q == StRampDn);

  // Clamp arithmetic carries one extra bit so a borrow or carry never wraps.
  assign t_up = {1'b0, target_q} + FStep;
  assign t_dn = {1'b0, target_q} - FStep;
  assign p_up = {1'b0, pwr_q} + PStep;
  assign p_dn = {1'b0, pwr_q} - PStep;
  assign f_up = {1'b0, freq_q} + FInc;
  assign f_dn = {1'b0, freq_q} - FInc;

  always_comb begin
    slew = freq_q;
    if (freq_q < target_q) begin
      slew = (f_up > {1'b0, target_q}) ? target_q : f_up[FREQ_W-1:0];
    end else if (freq_q > target_q) begin
      slew = (f_dn[FREQ_W] || f_dn[FREQ_W-1:0] < target_q) ? target_q : f_dn[FREQ_W-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    dir_d    = dir_q;
    freq_d   = freq_q;
    target_d = target_q;
    pwr_d    = pwr_q;
    tick_clr = 1'b0;

    if (state_q != StFstop && !m3forceStopI) begin
      if (finc && !fdec) begin
        target_d = (t_up > FMaxX) ? FMaxX[FREQ_W-1:0] : t_up[FREQ_W-1:0];
      end else if (fdec && !finc) begin
        target_d = (t_dn[FREQ_W] || t_dn < FMinX) ? FMin : t_dn[FREQ_W-1:0];
      end
      if (pinc && !pdec) begin
        pwr_d = (p_up > PMaxX) ? PMaxX[PWR_W-1:0] : p_up[PWR_W-1:0];
      end else if (pdec && !pinc) begin
        pwr_d = (p_dn[PWR_W] || p_dn < PMinX) ? PMinX[PWR_W-1:0] : p_dn[PWR_W-1:0];
      end
    end

    case (state_q)
      StIdle: begin
        en_d   = 1'b0;
        freq_d = '0;
        if (m3startI && !m3forceStopI) begin
          dir_d    = m3invRotateI;
          freq_d   = FMin;
          en_d     = 1'b1;
          state_d  = StRampUp;
          tick_clr = 1'b1;
        end
      end
      StRampUp, StRun: begin
        if (stop_req) begin
          state_d  = StRampDn;
          tick_clr = 1'b1;
        end else begin
          if (tick) freq_d = slew;
          if (state_q == StRampUp && freq_q == target_q) state_d = StRun;
        end
      end
      StRampDn: begin
        if (freq_q == FMin) begin
          state_d = StHold;
          en_d    = 1'b0;
          freq_d  = '0;
        end else if (tick) begin
          freq_d = (f_dn[FREQ_W] || f_dn < FMinX) ? FMin : f_dn[FREQ_W-1:0];
        end
      end
      StHold: begin
        en_d   = 1'b0;
        freq_d = '0;
        if (hold_cnt_q == HoldW'(STOP_HOLD - 1)) state_d = StIdle;
      end
      StFstop: begin
        en_d   = 1'b0;
        freq_d = '0;
        if (!m3forceStopI && !m3startI) state_d = StHold;
      end
      default: begin
        state_d = StIdle;
        en_d    = 1'b0;
        freq_d  = '0;
      end
    endcase

    if (m3forceStopI) begin
      state_d = StFstop;
      en_d    = 1'b0;
      freq_d  = '0;
    end
  end

  always_comb begin
    tick_cnt_d = '0;
    if (ramping && !tick_clr && !tick) tick_cnt_d = tick_cnt_q + 1'b1;
    hold_cnt_d = (state_q == StHold) ? hold_cnt_q + 1'b1 : '0;
    // Power follows the next-cycle enable so it drops on the same edge as the bridge.
    pwr_out_d  = en_d ? pwr_q : '0;
  end

  always_ff @(posedge clk50mhzI) begin
    if (!nRstI) begin
      state_q    <= StIdle;
      en_q       <= 1'b0;
      dir_q      <= 1'b0;
      freq_q     <= '0;
      target_q   <= FMin;
      pwr_q      <= PMinX[PWR_W-1:0];
      pwr_out_q  <= '0;
      prev_q     <= '0;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      dir_q      <= dir_d;
      freq_q     <= freq_d;
      target_q   <= target_d;
      pwr_q      <= pwr_d;
      pwr_out_q  <= pwr_out_d;
      prev_q     <= {m3freqINCi, m3freqDECi, m3powerINCi, m3powerDECi};
      tick_cnt_q <= tick_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign m3enO    = en_q;
  assign m3dirO   = dir_q;
  assign m3freqO  = freq_q;
  assign m3powerO = pwr_out_q;
  assign m3stateO = state_q;

endmodule

// File: tb/tb_m3_run_sequencer.sv
// Directed bench for m3_run_sequencer with short ramp and hold times; every expected value
// is a hand-computed constant checked a fixed number of cycles after a stimulus edge.
module tb_m3_run_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, fstop = 1'b0, inv = 1'b0;
  logic        finc = 1'b0, fdec = 1'b0, pinc = 1'b0, pdec = 1'b0;
  logic        en, dir;
  logic [15:0] freq;
  logic [7:0]  power;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  m3_run_sequencer #(
    .FREQ_MIN (10),
    .FREQ_MAX (20),
    .FREQ_STEP(5),
    .RAMP_TICK(4),
    .STOP_HOLD(8)
  ) dut (
    .clk50mhzI   (clk),
    .nRstI       (rst_n),
    .m3startI    (start),
    .m3forceStopI(fstop),
    .m3invRotateI(inv),
    .m3freqINCi  (finc),
    .m3freqDECi  (fdec),
    .m3powerINCi (pinc),
    .m3powerDECi (pdec),
    .m3enO       (en),
    .m3dirO      (dir),
    .m3freqO     (freq),
    .m3powerO    (power),
    .m3stateO    (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n active edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One press: {freqINC, freqDEC, powerINC, powerDEC} high for a cycle, then low for a cycle.
  task automatic press(input logic [3:0] m, input int times);
    repeat (times) begin
      {finc, fdec, pinc, pdec} = m;
      cycles(1);
      {finc, fdec, pinc, pdec} = 4'b0000;
      cycles(1);
    end
  endtask

  initial begin
    cycles(2);
    check("rst_state", state, 0);
    check("rst_en", en, 0);
    check("rst_freq", freq, 0);
    check("rst_power", power, 0);
    check("rst_dir", dir, 0);
    rst_n = 1'b1;
    cycles(1);

    // 1: target 10 -> 20, then ramp up
    press(4'b1000, 2);
    start = 1'b1;
    cycles(1);
    check("t1_state_rampup", state, 1);
    check("t1_freq_entry", freq, 10);
    check("t1_en", en, 1);
    check("t1_power", power, 32);
    cycles(4);
    check("t1_freq_first_tick", freq, 11);
    cycles(3);
    check("t1_freq_hold", freq, 11);
    cycles(33);
    check("t1_freq_top", freq, 20);
    check("t1_still_rampup", state, 1);
    cycles(1);
    check("t1_state_run", state, 2);
    check("t1_run_en", en, 1);
    check("t1_run_power", power, 32);

    // 2: target clamps, step down, simultaneous INC+DEC ignored
    press(4'b1000, 3);
    cycles(8);
    check("t2_clamp_max", freq, 20);
    press(4'b0100, 4);
    cycles(40);
    check("t2_freq_down", freq, 10);
    check("t2_state_run", state, 2);
    press(4'b1100, 1);
    cycles(12);
    check("t2_inc_dec_same", freq, 10);

    // 3: back to 20, then reverse
    press(4'b1000, 2);
    cycles(60);
    check("t3_freq_20", freq, 20);
    inv = 1'b1;
    cycles(1);
    check("t3_state_rampdn", state, 3);
    check("t3_dir_kept", dir, 0);
    cycles(40);
    check("t3_freq_min", freq, 10);
    check("t3_still_rampdn", state, 3);
    cycles(1);
    check("t3_state_hold", state, 4);
    check("t3_hold_en", en, 0);
    check("t3_hold_freq", freq, 0);
    check("t3_hold_power", power, 0);
    cycles(7);
    check("t3_hold_last", state, 4);
    cycles(1);
    check("t3_state_idle", state, 0);
    cycles(1);
    check("t3_restart", state, 1);
    check("t3_new_dir", dir, 1);
    check("t3_restart_freq", freq, 10);

    // 4: force stop mid ramp-up, presses ignored while stopped
    cycles(2);
    fstop = 1'b1;
    cycles(1);
    check("t4_state_fstop", state, 5);
    check("t4_en", en, 0);
    check("t4_freq", freq, 0);
    check("t4_power", power, 0);
    press(4'b0010, 3);
    fstop = 1'b0;
    cycles(2);
    check("t4_wait_start_low", state, 5);
    start = 1'b0;
    cycles(1);
    check("t4_state_hold", state, 4);
    cycles(7);
    check("t4_hold_last", state, 4);
    cycles(1);
    check("t4_state_idle", state, 0);

    // 5: power stepping and saturation
    inv = 1'b0;
    press(4'b0010, 13);
    check("t5_idle_power0", power, 0);
    check("t5_idle_state", state, 0);
    start = 1'b1;
    cycles(1);
    check("t5_power_240", power, 240);
    check("t5_dir0", dir, 0);
    press(4'b0010, 1);
    check("t5_power_255", power, 255);
    press(4'b0010, 1);
    check("t5_power_sat", power, 255);
    press(4'b0001, 1);
    check("t5_power_239", power, 239);
    press(4'b0001, 16);
    check("t5_power_floor", power, 32);

    // 6: reset during RUN
    cycles(60);
    check("t6_state_run", state, 2);
    rst_n = 1'b0;
    cycles(1);
    check("t6_state", state, 0);
    check("t6_en", en, 0);
    check("t6_freq", freq, 0);
    check("t6_power", power, 0);
    rst_n = 1'b1;
    cycles(1);
    check("t6_restart_freq", freq, 10);
    check("t6_restart_power", power, 32);
    cycles(1);
    check("t6_target_reset", state, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/m3_run_sequencer.md
Name: m3_run_sequencer

Overview:
Run-state controller for the three-phase motor drive. It turns operator controls (start, force-stop, reverse, freq/power up/down) into a registered command set for the PWM/commutation datapath: bridge enable, direction, electrical frequency and power duty. It ramps frequency at a fixed slew rate and enforces decel-then-off-hold before any direction reversal, so the bridge never reverses while energised. It sits between the panel inputs and the phase generator in motor602_rtl_top.

Parameters:
FREQ_W, 16, width of frequency command
PWR_W, 8, width of power/duty command
FREQ_MIN, 100, start/stop frequency and lower clamp of target
FREQ_MAX, 4000, upper clamp of target
FREQ_STEP, 50, target change per freq INC/DEC press
RAMP_INC, 1, frequency slew per ramp tick
RAMP_TICK, 50000, cycles per ramp tick (1 ms at 50 MHz)
PWR_MIN, 32, lower clamp and reset value of power
PWR_MAX, 255, upper clamp of power
PWR_STEP, 16, power change per press
STOP_HOLD, 500000, cycles the bridge stays off after stopping (10 ms)

Ports:
clk50mhzI  in  1  50 MHz clock; single clock domain
nRstI  in  1  reset, synchronous, active-low
m3startI  in  1  run request, level
m3forceStopI  in  1  emergency stop, level, highest priority
m3invRotateI  in  1  requested direction, level (1 = reverse)
m3freqINCi / m3freqDECi  in  1 each  freq target step, rising-edge sensitive
m3powerINCi / m3powerDECi  in  1 each  power step, rising-edge sensitive
m3enO  out  1  bridge enable to phase generator
m3dirO  out  1  latched direction
m3freqO  out  FREQ_W  current frequency command
m3powerO  out  PWR_W  current power command
m3stateO  out  3  state code, debug/LED

Behaviour:
- All outputs registered. Inputs already synchronised upstream.
- Reset (nRstI=0 at clock edge): state IDLE, m3enO=0, m3dirO=0, m3freqO=0, m3powerO=0; target=FREQ_MIN, powerReg=PWR_MIN, edge flops=0, counters=0.
- Edge detect: one previous-value flop per step input; press = in & ~prev. Target/powerReg update on the edge following the press cycle. INC and DEC pressed in the same cycle: ignored. Presses are accepted in every state except FSTOP.
- Clamp arithmetic in W+1 bits: target = min(target+FREQ_STEP, FREQ_MAX) / max(target−FREQ_STEP, FREQ_MIN); same for powerReg with PWR_MIN/MAX/STEP. No wrap.
- m3powerO = powerReg while m3enO=1, else 0 (tracks powerReg with one cycle latency).
- Ramp tick: counter 0..RAMP_TICK−1, cleared on entry to RAMPUP and RAMPDN; tick pulses when count = RAMP_TICK−1, i.e. the first slew occurs RAMP_TICK cycles after entry.
- States (m3stateO code):
  IDLE(0): en=0, freq=0. If start=1 and forceStop=0: latch dir=invRotateI, freq=FREQ_MIN, en=1 -> RAMPUP.
  RAMPUP(1): on tick, freq moves RAMP_INC toward target (never overshoots). freq==target -> RUN.
  RUN(2): on tick, freq slews toward target in either direction, at the same rate.
  RAMPUP/RUN exit: start=0 or invRotateI≠dir -> RAMPDN.
  RAMPDN(3): on tick, freq −= RAMP_INC, floored at FREQ_MIN. freq==FREQ_MIN -> HOLD with en=0, freq=0. start returning to 1 with the same dir does not abort the decel.
  HOLD(4): en=0; count STOP_HOLD cycles, then -> IDLE. IDLE restarts on the next cycle if start is still 1 (new dir latched).
  FSTOP(5): entered from any state on the edge after forceStop=1: en=0, freq=0, power=0. Leave to HOLD only when forceStop=0 and start=0.
- Priority: reset > forceStop > stop/reverse > ramp slew > step presses.
- dir changes only in the IDLE->RAMPUP transition.

Test Plan:
(Params: FREQ_MIN=10, FREQ_MAX=20, FREQ_STEP=5, RAMP_TICK=4, STOP_HOLD=8, others default.)
1. Two freqINC pulses, then start=1 -> target=20; RAMPUP with freq=10, freq=11 after 4 cycles, freq=20 after 40 cycles, then state RUN, en=1, power=32.
2. Three freqINC pulses -> target clamps at 20. Four freqDEC pulses -> target=10. INC+DEC in the same cycle -> target unchanged.
3. RUN at 20, dir=0; set invRotate=1 -> RAMPDN, freq 20->10 over 40 cycles; HOLD en=0 for 8 cycles; IDLE; RAMPUP with dir=1, freq=10.
4. forceStop=1 mid-RAMPUP -> next edge state=5, en/freq/power=0. Presses ignored. Drop forceStop, then start -> HOLD 8 cycles -> IDLE.
5. Power: PWR_STEP presses from 32 up to 240, one more -> 255 (saturated). DEC below 32 -> 32. In IDLE m3powerO=0 while powerReg is retained.
6. nRstI=0 for one cycle during RUN -> next edge all outputs 0, state IDLE, target=10, powerReg=32, dir=0.
